if_fetch: RTL and testbench

Instruction-fetch controller directly upstream of the `PC` register. It chooses the next PC value (sequential, redirect or reset vector) and drives `pc_en`/`pc_in`. It issues instruction-memory reads at the current `pc_out` and buffers the returned instructions in a small FIFO. The FIFO feeds decode through a valid/ready handshake.

---
 rtl/if_fetch.sv | 102 ++++++++++
 tb/tb_if_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch controller feeding the PC register, issuing imem reads and buffering fetched words for decode (optional IF_BYPASS_EN forwards a response straight to decode)
module if_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_out,
  output logic        pc_en,
  output logic [31:0] pc_in,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);
  localparam int AW = $clog2(BUF_DEPTH);
  typedef enum logic [1:0] {BOOT, REQ, WAIT, FLUSH} state_t;
  state_t        state_q, state_d;
  logic          out_q, out_d;
  logic [31:0]   req_pc_q;
  logic [31:0]   instr_q [BUF_DEPTH];
  logic [31:0]   ipc_q [BUF_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [AW+1:0] occ;
  logic          hs, redir, rsp_wait, byp, push, pop;
  assign redir    = redirect_valid & (state_q != BOOT);
  assign rsp_wait = imem_rsp_valid & (state_q == WAIT);
  assign occ      = {1'b0, cnt_q} + {{(AW+1){1'b0}}, out_q};
  assign imem_req_valid = rst & (state_q == REQ) & (occ < (AW+2)'(BUF_DEPTH));
  assign imem_addr = pc_out;
  assign hs        = imem_req_valid & imem_req_ready;
`ifdef IF_BYPASS_EN
  assign byp = rsp_wait & ~redir & (cnt_q == '0) & id_ready;
`else
  assign byp = 1'b0;
`endif
  assign push     = rsp_wait & ~redir & ~byp;
  assign pop      = id_ready & (cnt_q != '0);
  assign id_valid = byp | (cnt_q != '0);
  assign id_instr = byp ? imem_rsp_data : instr_q[rd_q];
  assign id_pc    = byp ? req_pc_q : ipc_q[rd_q];
  // state register, outstanding-request flag and captured request address
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= BOOT;
      out_q    <= 1'b0;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (hs) req_pc_q <= pc_out;
    end
  end
  // next state: a redirect lands in FLUSH only while a response is still owed
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = REQ;
      REQ:     state_d = hs ? (redir ? FLUSH : WAIT) : REQ;
      WAIT:    state_d = imem_rsp_valid ? REQ : (redir ? FLUSH : WAIT);
      default: state_d = imem_rsp_valid ? REQ : FLUSH;
    endcase
    out_d = (state_d == WAIT) | (state_d == FLUSH);
  end
  // PC update: reset vector in BOOT, redirect overrides the sequential +4
  always_comb begin
    pc_en = rst & ((state_q == BOOT) | redir | hs);
    pc_in = !rst ? '0 : (state_q == BOOT) ? RESET_VEC : redir ? redirect_pc : hs ? pc_out + 32'd4 : '0;
  end
  // instruction buffer; a redirect empties it and beats any push or pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else if (redir) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        instr_q[wr_q] <= imem_rsp_data;
        ipc_q[wr_q]   <= req_pc_q;
        wr_q          <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a PC register and a variable-latency memory model
module tb_if_fetch;
`ifdef IF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic        clk = 0, rst = 0;
  logic [31:0] pc_out = 0;
  logic        pc_en, imem_req_valid, imem_rsp_valid, id_valid;
  logic [31:0] pc_in, imem_addr, imem_rsp_data, id_instr, id_pc;
  logic        imem_req_ready = 1, redirect_valid = 0, id_ready = 1, force_rsp = 0;
  logic [31:0] redirect_pc = 0;
  logic        busy = 0;
  int          cnt = 0, mem_lat = 1, checks = 0, errors = 0;
  logic [31:0] a_l = 0;

  if_fetch #(.RESET_VEC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .pc_en(pc_en), .pc_in(pc_in),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_en) pc_out <= pc_in;

  always @(posedge clk) begin
    if (!rst) busy <= 0;
    else if (imem_req_valid && imem_req_ready) begin
      busy <= 1;
      cnt  <= mem_lat;
      a_l  <= imem_addr;
    end else if (busy) begin
      if (cnt == 1) busy <= 0;
      else cnt <= cnt - 1;
    end
  end
  assign imem_rsp_valid = (busy && cnt == 1) || force_rsp;
  assign imem_rsp_data  = a_l + 32'h1300_0000;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_id(input string tag, input logic [31:0] epc, input logic [31:0] ein);
    for (int i = 0; i < 12 && !id_valid; i++) tick();
    chk({tag, "_valid"}, id_valid, 1);
    chk({tag, "_pc"}, id_pc, epc);
    chk({tag, "_instr"}, id_instr, ein);
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_pc_en", pc_en, 0);
    chk("rst_pc_in", pc_in, 0);
    chk("rst_req", imem_req_valid, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    rst = 1;
    #1;
    chk("boot_pc_en", pc_en, 1);
    chk("boot_pc_in", pc_in, 32'h100);
    tick();
    chk("req0_valid", imem_req_valid, 1);
    chk("req0_addr", imem_addr, 32'h100);
    chk("req0_pc_en", pc_en, 1);
    chk("req0_pc_in", pc_in, 32'h104);
    tick();
    chk("wait_req", imem_req_valid, 0);
    chk("rsp_latency", id_valid, BYP);
    wait_id("seq0", 32'h100, 32'h1300_0100);
    wait_id("seq1", 32'h104, 32'h1300_0104);
    wait_id("seq2", 32'h108, 32'h1300_0108);

    rst = 0;
    tick();
    tick();
    rst = 1;
    id_ready = 0;
    repeat (12) tick();
    chk("full_valid", id_valid, 1);
    chk("full_pc", id_pc, 32'h100);
    chk("full_instr", id_instr, 32'h1300_0100);
    chk("full_req", imem_req_valid, 0);
    chk("full_pcout", pc_out, 32'h108);
    id_ready = 1;
    #1;
    chk("drain0_pc", id_pc, 32'h100);
    tick();
    chk("drain1_valid", id_valid, 1);
    chk("drain1_pc", id_pc, 32'h104);
    chk("drain1_instr", id_instr, 32'h1300_0104);
    tick();
    wait_id("drain2", 32'h108, 32'h1300_0108);

    mem_lat = 2;
    for (int i = 0; i < 10 && !imem_req_valid; i++) tick();
    chk("t3_hs", imem_req_valid, 1);
    tick();
    redirect_valid = 1;
    redirect_pc = 32'h0000_beef;
    #1;
    chk("t3_pc_en", pc_en, 1);
    chk("t3_pc_in", pc_in, 32'hbeef);
    tick();
    redirect_valid = 0;
    #1;
    chk("t3_pcout", pc_out, 32'hbeef);
    chk("t3_id_valid", id_valid, 0);
    chk("t3_flush_req", imem_req_valid, 0);
    chk("t3_stale_rsp", imem_rsp_valid, 1);
    tick();
    chk("t3_req", imem_req_valid, 1);
    chk("t3_addr", imem_addr, 32'hbeef);
    wait_id("t3", 32'hbeef, 32'h1300_beef);

    mem_lat = 1;
    id_ready = 0;
    for (int i = 0; i < 12 && !(imem_req_valid && id_valid); i++) tick();
    chk("t4_hs_pop", imem_req_valid & id_valid, 1);
    id_ready = 1;
    redirect_valid = 1;
    redirect_pc = 32'h0000_2000;
    #1;
    chk("t4_pc_en", pc_en, 1);
    chk("t4_pc_in", pc_in, 32'h2000);
    tick();
    redirect_valid = 0;
    #1;
    chk("t4_id_valid", id_valid, 0);
    chk("t4_pcout", pc_out, 32'h2000);
    chk("t4_flush_req", imem_req_valid, 0);
    chk("t4_stale_rsp", imem_rsp_valid, 1);
    tick();
    chk("t4_req", imem_req_valid, 1);
    chk("t4_addr", imem_addr, 32'h2000);
    wait_id("t4", 32'h2000, 32'h1300_2000);

    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    #1;
    for (int i = 0; i < 10 && !(imem_req_valid && imem_addr == 32'hFFFF_FFFC); i++) tick();
    chk("t5_req", imem_req_valid, 1);
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t5_pc_en", pc_en, 1);
    chk("t5_pc_in", pc_in, 32'h0);
    wait_id("t5a", 32'hFFFF_FFFC, 32'h12FF_FFFC);
    wait_id("t5b", 32'h0, 32'h1300_0000);

    id_ready = 0;
    mem_lat = 2;
    for (int i = 0; i < 12 && !(imem_req_valid && id_valid); i++) tick();
    chk("t6_hs_entry", imem_req_valid & id_valid, 1);
    tick();
    chk("t6_wait_entry", id_valid, 1);
    rst = 0;
    tick();
    chk("t6_id_valid", id_valid, 0);
    chk("t6_req", imem_req_valid, 0);
    chk("t6_pc_en", pc_en, 0);
    rst = 1;
    force_rsp = 1;
    #1;
    chk("t6_boot_pc_en", pc_en, 1);
    chk("t6_boot_pc_in", pc_in, 32'h100);
    chk("t6_boot_id_valid", id_valid, 0);
    tick();
    force_rsp = 0;
    id_ready = 1;
    mem_lat = 1;
    #1;
    wait_id("t6", 32'h100, 32'h1300_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
